// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM state and last-owner encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_DM = 2'd2
    } owner_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between instruction fetch and the MEM stage,
// with DM priority, an IF anti-starvation streak counter and per-requester stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,
    input  logic                  dm_read,
    input  logic                  dm_write,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_valid,
    output logic                  dm_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output arb_state_t            dbg_state,
    output logic [STREAK_W-1:0]   dbg_streak
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    // Handshake: requesters hold req level with stable fields until their one-cycle
    // x_valid pulse; the memory side holds mem_req and every mem_* field stable until
    // a cycle with mem_req & mem_ready, which completes the access.

    arb_state_t          state;
    owner_t              last_owner;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;

    logic dm_any;
    logic arb_open;
    logic if_cand;
    logic dm_cand;
    logic grant_if;
    logic grant_dm;

    always_comb begin
        dm_any   = dm_read | dm_write;
        arb_open = (state == IDLE) || (state == RESP);
        // In RESP the owner's request is the one just served, so only the other side competes.
        if_cand  = arb_open && if_req && !((state == RESP) && (last_owner == OWN_IF));
        dm_cand  = arb_open && dm_any && !((state == RESP) && (last_owner == OWN_DM));
        grant_if = if_cand && (!dm_cand || (streak == LIMIT));
        grant_dm = dm_cand && !grant_if;
    end

    always_comb begin
        streak_next = streak;
        if (grant_if || !if_req) begin
            streak_next = '0;
        end else if (grant_dm && (streak != LIMIT)) begin
            streak_next = streak + 1'b1;
        end
    end

    assign if_stall   = if_req & ~if_valid;
    assign dm_stall   = dm_any & ~dm_valid;
    assign dbg_state  = state;
    assign dbg_streak = streak;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= NONE;
            streak     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            streak   <= streak_next;
            case (state)
                IDLE, RESP: begin
                    if (grant_if) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= {BE_W{1'b1}};
                        state     <= BUSY_IF;
                    end else if (grant_dm) begin
                        mem_req   <= 1'b1;
                        // A simultaneous read+write strobe is treated as a store.
                        mem_we    <= dm_write;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_write ? dm_be : {BE_W{1'b1}};
                        state     <= BUSY_DM;
                    end else begin
                        state     <= IDLE;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        if_rdata   <= mem_rdata;
                        if_valid   <= 1'b1;
                        last_owner <= OWN_IF;
                        state      <= RESP;
                    end
                end
                BUSY_DM: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        dm_rdata   <= mem_rdata;
                        dm_valid   <= 1'b1;
                        last_owner <= OWN_DM;
                        state      <= RESP;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_valid;
    logic            if_stall;
    logic            dm_read;
    logic            dm_write;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [BW-1:0]   dm_be;
    logic [DW-1:0]   dm_rdata;
    logic            dm_valid;
    logic            dm_stall;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [BW-1:0]   mem_be;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;
    arb_state_t      dbg_state;
    logic [STREAK_W-1:0] dbg_streak;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_streak(dbg_streak)
    );

    // ---------------- clock / memory contents ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    // ---------------- reference model ----------------
    // Who is using the memory: 0 nobody, 1 fetch, 2 data. resp_to: whose result is being returned.
    bit            m_busy;
    int            m_user;
    int            m_resp_to;
    int            m_streak;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    bit            m_ifv;
    bit            m_dmv;
    bit            m_dm_load;
    bit            m_after_reset;
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] dm_exp_q[$];

    task automatic model_step();
        bit want_if;
        bit want_dm;
        bit pick_if;
        bit pick_dm;
        m_after_reset = reset;
        if (reset) begin
            m_busy = 0; m_user = 0; m_resp_to = 0; m_streak = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
            m_ifv = 0; m_dmv = 0; m_dm_load = 0;
            if_exp_q.delete();
            dm_exp_q.delete();
            return;
        end
        want_if = !m_busy && if_req && (m_resp_to != 1);
        want_dm = !m_busy && (dm_read || dm_write) && (m_resp_to != 2);
        pick_if = want_if && (!want_dm || (m_streak == LIMIT));
        pick_dm = want_dm && !pick_if;
        if (pick_if || !if_req)   m_streak = 0;
        else if (pick_dm)         m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
        m_ifv = 0;
        m_dmv = 0;
        if (m_busy) begin
            if (mem_ready) begin
                m_busy    = 0;
                m_resp_to = m_user;
                if (m_user == 1) begin
                    m_ifv = 1;
                    if_exp_q.push_back(mem_word(m_addr));
                end else begin
                    m_dmv     = 1;
                    m_dm_load = !m_we;
                    if (!m_we) dm_exp_q.push_back(mem_word(m_addr));
                end
            end
        end else begin
            m_resp_to = 0;
            if (pick_if) begin
                m_busy = 1; m_user = 1; m_we = 0;
                m_addr = if_addr; m_wdata = '0; m_be = '1;
            end else if (pick_dm) begin
                m_busy = 1; m_user = 2; m_we = dm_write;
                m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_write ? dm_be : '1;
            end
        end
    endtask

    function automatic arb_state_t exp_state();
        if (m_busy)         return (m_user == 1) ? BUSY_IF : BUSY_DM;
        if (m_resp_to != 0) return RESP;
        return IDLE;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] exp_d;
        chk("mem_req",   32'(mem_req),   32'(m_busy));
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  mem_addr,       m_addr);
        chk("mem_wdata", mem_wdata,      m_wdata);
        chk("mem_be",    32'(mem_be),    32'(m_be));
        chk("if_valid",  32'(if_valid),  32'(m_ifv));
        chk("dm_valid",  32'(dm_valid),  32'(m_dmv));
        chk("if_stall",  32'(if_stall),  32'(if_req & ~m_ifv));
        chk("dm_stall",  32'(dm_stall),  32'((dm_read | dm_write) & ~m_dmv));
        chk("state",     32'(dbg_state), 32'(exp_state()));
        chk("streak",    32'(dbg_streak), 32'(m_streak));
        if (m_ifv && if_exp_q.size() > 0) begin
            exp_d = if_exp_q.pop_front();
            chk("if_rdata", if_rdata, exp_d);
        end
        if (m_dmv && m_dm_load && dm_exp_q.size() > 0) begin
            exp_d = dm_exp_q.pop_front();
            chk("dm_rdata", dm_rdata, exp_d);
        end
        if (m_after_reset) begin
            chk("if_rdata_rst", if_rdata, 32'h0);
            chk("dm_rdata_rst", dm_rdata, 32'h0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_if(input logic req, input logic [AW-1:0] a);
        if_req  = req;
        if_addr = a;
    endtask

    task automatic set_dm(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [BW-1:0] be);
        dm_read  = rd;
        dm_write = wr;
        dm_addr  = a;
        dm_wdata = wd;
        dm_be    = be;
    endtask

    task automatic drive_random();
        int k;
        reset     = ($urandom_range(0, 399) == 0);
        mem_ready = ($urandom_range(0, 2) != 0);
        if (if_req && m_ifv) begin
            if_req  = 1'($urandom_range(0, 1));
            if_addr = AW'($urandom_range(0, 1023)) << 2;
        end else if (if_req) begin
            if ($urandom_range(0, 39) == 0) if_req = 1'b0;
        end else if (!(m_busy && m_user == 1) && $urandom_range(0, 1) == 1) begin
            if_req  = 1'b1;
            if_addr = AW'($urandom_range(0, 1023)) << 2;
        end
        if ((dm_read || dm_write) && !m_dmv) begin
            if ($urandom_range(0, 39) == 0) begin
                dm_read  = 1'b0;
                dm_write = 1'b0;
            end
        end else if (!(m_busy && m_user == 2) && $urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, 9);
            set_dm(k < 5 || k == 9, k >= 5, AW'($urandom_range(0, 1023)) << 2,
                   $urandom, BW'($urandom_range(1, 15)));
        end else begin
            dm_read  = 1'b0;
            dm_write = 1'b0;
        end
    endtask

    // ---------------- directed steps then random traffic ----------------
    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        set_if(1'b0, '0);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        ticks(2);
        reset = 1'b0;
        tick();

        // Lone fetch with zero-wait memory.
        mem_ready = 1'b1;
        set_if(1'b1, 32'h10);
        tick();
        chk("t1_mem_addr", mem_addr, 32'h10);
        tick();
        chk("t1_if_valid", 32'(if_valid), 32'h1);
        set_if(1'b0, '0);
        ticks(2);

        // Load with three wait states.
        set_dm(1'b1, 1'b0, 32'h100, '0, '0);
        mem_ready = 1'b0;
        ticks(4);
        mem_ready = 1'b1;
        tick();
        chk("t2_dm_valid", 32'(dm_valid), 32'h1);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        ticks(2);

        // Simultaneous fetch and store: store goes first.
        set_if(1'b1, 32'h20);
        set_dm(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
        tick();
        chk("t3_mem_be", 32'(mem_be), 32'h3);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_dmv) set_dm(1'b0, 1'b0, '0, '0, '0);
            if (m_ifv) set_if(1'b0, '0);
        end

        // Both requesters held high.
        set_if(1'b1, 32'h40);
        set_dm(1'b1, 1'b0, 32'h300, '0, '0);
        ticks(12);
        set_if(1'b0, '0);
        set_dm(1'b0, 1'b0, '0, '0, '0);
        ticks(4);

        // Fetch withdrawn while the access is in flight.
        set_if(1'b1, 32'h50);
        mem_ready = 1'b0;
        ticks(2);
        set_if(1'b0, '0);
        tick();
        mem_ready = 1'b1;
        ticks(3);

        // Reset while a load waits on memory, then a fresh fetch.
        set_dm(1'b1, 1'b0, 32'h400, '0, '0);
        mem_ready = 1'b0;
        ticks(2);
        reset = 1'b1;
        set_dm(1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("t5_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick();
        set_if(1'b1, 32'h60);
        mem_ready = 1'b1;
        ticks(2);
        set_if(1'b0, '0);
        ticks(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
